uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx_param.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types for the parameterised UART receiver: FSM state encoding and
// parity-mode constants used by the PARITY parameter.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_BRK   = 3'd5
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the
// idle-high level so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with a one-word valid/ready output holding register.
// Parity checking is built only when UART_RX_PARAM_PARITY_EN is defined.
module uart_rx_param
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in__rx,
    input  logic                 in__ready,
    output logic [DATA_BITS-1:0] out__data,
    output logic                 out__valid,
    output logic                 out__ferr,
    output logic                 out__perr,
    output logic                 out__ovr,
    output uart_state_e          dbg_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_RX_PARAM_PARITY_EN
    localparam logic PAR_ON       = (PARITY != PAR_NONE);
    localparam logic PAR_ODD_MODE = (PARITY == PAR_ODD);
    logic par_err;
    logic done_perr;
`endif

    uart_state_e          state;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_acc;
    logic                 done;
    logic [DATA_BITS-1:0] done_data;
    logic                 done_ferr;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in__rx),
        .q   (rx_s)
    );

    assign dbg_state = state;

    // Frame FSM: every sample is taken at a bit centre; done pulses for one
    // cycle with the finished frame staged in done_* for the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            ferr_acc  <= 1'b0;
            done      <= 1'b0;
            done_data <= '0;
            done_ferr <= 1'b0;
`ifdef UART_RX_PARAM_PARITY_EN
            par_err   <= 1'b0;
            done_perr <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= ST_START;
                end
                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == BIT_LAST) begin
                            stop_idx <= 1'b0;
                            ferr_acc <= 1'b0;
`ifdef UART_RX_PARAM_PARITY_EN
                            state    <= PAR_ON ? ST_PAR : ST_STOP;
`else
                            state    <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARAM_PARITY_EN
                ST_PAR: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        par_err <= ((^shreg) ^ rx_s) != PAR_ODD_MODE;
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            done      <= 1'b1;
                            done_data <= shreg;
                            done_ferr <= ferr_acc | ~rx_s;
`ifdef UART_RX_PARAM_PARITY_EN
                            done_perr <= par_err;
`endif
                            state     <= rx_s ? ST_IDLE : ST_BRK;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                            ferr_acc <= ferr_acc | ~rx_s;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BRK: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake: out__valid holds data/flags stable until a cycle with
    // in__ready high (the transfer). A frame finishing while a word is held
    // and not transferring that cycle is dropped and sets out__ovr, which
    // clears on the next transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out__data  <= '0;
            out__valid <= 1'b0;
            out__ferr  <= 1'b0;
            out__ovr   <= 1'b0;
`ifdef UART_RX_PARAM_PARITY_EN
            out__perr  <= 1'b0;
`endif
        end else begin
            if (out__valid && in__ready) begin
                out__valid <= 1'b0;
                out__ovr   <= 1'b0;
            end
            if (done) begin
                if (!out__valid || in__ready) begin
                    out__valid <= 1'b1;
                    out__data  <= done_data;
                    out__ferr  <= done_ferr;
`ifdef UART_RX_PARAM_PARITY_EN
                    out__perr  <= done_perr;
`endif
                end else begin
                    out__ovr <= 1'b1;
                end
            end
        end
    end

`ifndef UART_RX_PARAM_PARITY_EN
    assign out__perr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: a word-level expected queue checked on every
// transfer, plus literal checks on reset, glitch, break, overrun and parity cases.
module tb_uart_rx_param;
    import uart_rx_pkg::*;

    localparam int CPB = 16;
`ifdef UART_RX_PARAM_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in__rx = 1'b1;
    logic        in__ready = 1'b0;
    logic [7:0]  out__data;
    logic        out__valid;
    logic        out__ferr;
    logic        out__perr;
    logic        out__ovr;
    uart_state_e dbg_state;

    int total = 0;
    int bad = 0;
    int valid_cycles = 0;
    int vc0;

    // entry = {data[7:0], ferr, perr, ovr-at-transfer}
    logic [10:0] exp_q[$];
    logic [10:0] e;

    uart_rx_param #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY       (PAR_EVEN),
        .STOP_BITS    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in__rx     (in__rx),
        .in__ready  (in__ready),
        .out__data  (out__data),
        .out__valid (out__valid),
        .out__ferr  (out__ferr),
        .out__perr  (out__perr),
        .out__ovr   (out__ovr),
        .dbg_state  (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Even-parity rule: data bits plus parity bit must XOR to 0.
    function automatic logic model_perr(input logic [7:0] d, input logic p);
        logic ones;
        ones = 1'b0;
        for (int i = 0; i < 8; i++) ones = ones ^ d[i];
        return PAR_EN && ((ones ^ p) != 1'b0);
    endfunction

    // scoreboard: every transfer must match the head of the expected queue
    always @(negedge clk) begin
        if (rst) begin
            if (out__valid) valid_cycles++;
            if (out__valid && in__ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got data %0h, no word expected", out__data);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", {24'd0, out__data}, {24'd0, e[10:3]});
                    check("word_ferr", {31'd0, out__ferr}, {31'd0, e[2]});
                    check("word_perr", {31'd0, out__perr}, {31'd0, e[1]});
                    check("word_ovr",  {31'd0, out__ovr},  {31'd0, e[0]});
                end
            end
        end
    end

    // driver tasks; all input changes happen 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic line(input logic b, input int n);
        in__rx = b;
        tick(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_bit, input int stop_len);
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(d[i], CPB);
        if (PAR_EN) line(p, CPB);
        line(stop_bit, stop_len);
    endtask

    task automatic expect_word(input logic [7:0] d, input logic ferr, input logic perr, input logic ovr);
        exp_q.push_back({d, ferr, perr, ovr});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        // reset state
        tick(3);
        check("rst_valid", {31'd0, out__valid}, 0);
        check("rst_data",  {24'd0, out__data}, 0);
        check("rst_ferr",  {31'd0, out__ferr}, 0);
        check("rst_perr",  {31'd0, out__perr}, 0);
        check("rst_ovr",   {31'd0, out__ovr}, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b1;
        tick(5);

        // 0xA5 with ready held: exactly one valid cycle
        in__ready = 1'b1;
        vc0 = valid_cycles;
        expect_word(8'hA5, 1'b0, model_perr(8'hA5, 1'b0), 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, CPB);
        tick(10);
        drain("a5_drain");
        check("a5_valid_width", valid_cycles - vc0, 1);

        // 4-clock glitch is rejected
        vc0 = valid_cycles;
        line(1'b0, 4);
        line(1'b1, 40);
        check("glitch_no_valid", valid_cycles - vc0, 0);
        check("glitch_idle", dbg_state, ST_IDLE);

        // framing error with line held low, then recovery
        expect_word(8'h3C, 1'b1, model_perr(8'h3C, 1'b0), 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 20);
        check("brk_state", dbg_state, ST_BRK);
        line(1'b0, 20);
        check("brk_hold", dbg_state, ST_BRK);
        line(1'b1, 32);
        expect_word(8'h81, 1'b0, model_perr(8'h81, 1'b0), 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, CPB);
        tick(10);
        drain("ferr_drain");

        // overrun: 0x11 held, 0x22 dropped
        in__ready = 1'b0;
        expect_word(8'h11, 1'b0, model_perr(8'h11, 1'b0), 1'b1);
        send_frame(8'h11, 1'b0, 1'b1, CPB);
        send_frame(8'h22, 1'b0, 1'b1, CPB);
        tick(4);
        check("ovr_valid", {31'd0, out__valid}, 1);
        check("ovr_data",  {24'd0, out__data}, 32'h11);
        check("ovr_flag",  {31'd0, out__ovr}, 1);
        in__ready = 1'b1;
        tick(1);
        in__ready = 1'b0;
        check("ovr_after_valid", {31'd0, out__valid}, 0);
        check("ovr_after_flag",  {31'd0, out__ovr}, 0);
        drain("ovr_drain");

        // 0x07 with parity bit 0 (wrong for even parity), then with parity bit 1
        expect_word(8'h07, 1'b0, model_perr(8'h07, 1'b0), 1'b0);
        send_frame(8'h07, 1'b0, 1'b1, CPB);
        tick(4);
        check("p07_data", {24'd0, out__data}, 32'h07);
        check("p07_perr", {31'd0, out__perr}, {31'd0, PAR_EN});
        in__ready = 1'b1;
        tick(1);
        expect_word(8'h07, 1'b0, model_perr(8'h07, 1'b1), 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, CPB);
        tick(10);
        drain("par_drain");

        // reset during data bit 3 of a frame, then 0x5A
        line(1'b0, CPB);
        line(1'b1, CPB);
        line(1'b1, CPB);
        line(1'b1, CPB);
        line(1'b0, 8);
        rst = 1'b0;
        #1;
        check("midrst_data",  {24'd0, out__data}, 0);
        check("midrst_valid", {31'd0, out__valid}, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        in__rx = 1'b1;
        tick(3);
        check("midrst_hold_valid", {31'd0, out__valid}, 0);
        rst = 1'b1;
        tick(3);
        expect_word(8'h5A, 1'b0, model_perr(8'h5A, 1'b0), 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, CPB);
        tick(10);
        drain("post_rst_drain");
        check("post_rst_data", {24'd0, out__data}, 32'h5A);
        check("post_rst_ferr", {31'd0, out__ferr}, 0);
        check("post_rst_ovr",  {31'd0, out__ovr}, 0);

        tick(20);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
